// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: turns single-cycle event pulses into visible LED flashes.
// Each accepted event gives one ON_CYCLES-long flash followed by a GAP_CYCLES
// dark gap. Events arriving while busy are queued in a saturating counter, and
// a sticky flag records any dropped events.
//
// Build option: LED_PULSE_ACTIVE_LOW_EN inverts led_out (lit when 0, resets to 1).
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   pulse_in   event request, one event per cycle sampled high
//   clear_ovf  synchronous clear of overflow
//   led_out    LED drive (registered)
//   busy       high whenever not idle (registered)
//   pending    queued events not yet flashed (registered)
//   overflow   sticky: an event was dropped on a saturated queue (registered)
module led_pulse_stretcher #(
  parameter int unsigned ON_CYCLES  = 10_000_000,
  parameter int unsigned GAP_CYCLES = 5_000_000,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pulse_in,
  input  logic              clear_ovf,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

`ifdef LED_PULSE_ACTIVE_LOW_EN
  localparam logic LED_LIT = 1'b0;
`else
  localparam logic LED_LIT = 1'b1;
`endif

  logic [1:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [PEND_W-1:0] pend_nx;
  logic              ovf_nx;
  logic              led_nx;
  logic              busy_nx;
  logic              inc, dec, consumed;

  // State, timer and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      led_out  <= ~LED_LIT;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pending  <= pend_nx;
      overflow <= ovf_nx;
      led_out  <= led_nx;
      busy     <= busy_nx;
    end
  end

  // Next-state, timer, pending accounting and output decode
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pending;
    ovf_nx   = overflow;
    inc      = 1'b0;
    dec      = 1'b0;
    consumed = 1'b0;

    case (state)
      S_IDLE: begin
        if (pulse_in) begin
          state_nx = S_ON;
          cnt_nx   = ON_LOAD;
          consumed = 1'b1;
        end
      end
      S_ON: begin
        if (cnt == '0) begin
          state_nx = S_GAP;
          cnt_nx   = GAP_LOAD;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          if (pending != '0) begin
            state_nx = S_ON;
            cnt_nx   = ON_LOAD;
            dec      = 1'b1;
          end else if (pulse_in) begin
            // Empty queue: the pulse starts the next flash directly
            state_nx = S_ON;
            cnt_nx   = ON_LOAD;
            consumed = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase

    inc = pulse_in & ~consumed;

    // Coincident increment and decrement leave the queue unchanged
    if (inc && !dec) begin
      if (pending == PEND_MAX) begin
        ovf_nx = 1'b1;
      end else begin
        pend_nx = pending + PEND_ONE;
      end
    end else if (dec && !inc) begin
      pend_nx = pending - PEND_ONE;
    end

    // A new overflow in the same cycle beats the clear
    if (clear_ovf && !(inc && !dec && pending == PEND_MAX)) begin
      ovf_nx = 1'b0;
    end

    led_nx  = (state_nx == S_ON) ? LED_LIT : ~LED_LIT;
    busy_nx = (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Bench for led_pulse_stretcher with ON=4, GAP=3, PEND_W=2: a vector table,
// hand-written corner sequences, and random traffic against a timeline model.
module tb_led_pulse_stretcher;

  localparam int unsigned ON_C   = 4;
  localparam int unsigned GAP_C  = 3;
  localparam int unsigned PW     = 2;
  localparam int          PERIOD = ON_C + GAP_C;
  localparam int          PMAX   = (1 << PW) - 1;

`ifdef LED_PULSE_ACTIVE_LOW_EN
  localparam logic ACT_LOW = 1'b1;
`else
  localparam logic ACT_LOW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pulse_in;
  logic          clear_ovf;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  led_pulse_stretcher #(
    .ON_CYCLES (ON_C),
    .GAP_CYCLES(GAP_C),
    .PEND_W    (PW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pulse_in (pulse_in),
    .clear_ovf(clear_ovf),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic p;
    logic c;
    int   led;
    int   busy;
    int   pend;
    int   ovf;
  } vec_t;

  vec_t vecs[$];

  // Timeline model: a flash starting at edge s is lit after edges s..s+ON-1,
  // dark through s+PERIOD-1, and the next flash may start at edge s+PERIOD.
  int cyc;
  bit m_act;
  int m_start;
  int m_pend;
  bit m_ovf;
  int e_led, e_busy;

  function automatic void model_reset();
    cyc = 0; m_act = 0; m_start = 0; m_pend = 0; m_ovf = 0;
    e_led = 0; e_busy = 0;
  endfunction

  function automatic void model_step(input bit p, input bit c);
    bit inc = 0, dec = 0, set = 0;
    if (!m_act) begin
      if (p) begin m_act = 1; m_start = cyc; end
    end else if (cyc == m_start + PERIOD) begin
      if (m_pend > 0) begin m_start = cyc; dec = 1; inc = p; end
      else if (p) m_start = cyc;
      else m_act = 0;
    end else begin
      inc = p;
    end
    if (inc && !dec) begin
      if (m_pend == PMAX) set = 1; else m_pend++;
    end else if (dec && !inc) begin
      m_pend--;
    end
    if (set) m_ovf = 1; else if (c) m_ovf = 0;
    e_busy = m_act ? 1 : 0;
    e_led  = (m_act && (cyc - m_start) < ON_C) ? 1 : 0;
    cyc++;
  endfunction

  function automatic int lit();
    return int'(led_out ^ ACT_LOW);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic c);
    pulse_in  = p;
    clear_ovf = c;
    @(posedge clk);
    #1;
    model_step(p, c);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_led"},  lit(), e_led);
    chk({tag, "_busy"}, int'(busy), e_busy);
    chk({tag, "_pend"}, int'(pending), m_pend);
    chk({tag, "_ovf"},  int'(overflow), int'(m_ovf));
  endtask

  function automatic void add(input logic p, input int led, input int b, input int pd);
    vec_t v;
    v.p = p; v.c = 1'b0; v.led = led; v.busy = b; v.pend = pd; v.ovf = 0;
    vecs.push_back(v);
  endfunction

  initial begin
    int rises;
    int prev;
    int guard;

    // Single flash, then an IDLE pulse, then pulses on the last gap cycle with
    // pending 0 (direct restart) and pending 1 (inc and dec coincide)
    add(1,1,1,0); add(0,1,1,0); add(0,1,1,0); add(0,1,1,0);
    add(0,0,1,0); add(0,0,1,0); add(0,0,1,0); add(0,0,0,0);
    add(1,1,1,0); add(0,1,1,0); add(0,1,1,0); add(0,1,1,0);
    add(0,0,1,0); add(0,0,1,0); add(0,0,1,0);
    add(1,1,1,0); add(1,1,1,1); add(0,1,1,1); add(0,1,1,1);
    add(0,0,1,1); add(0,0,1,1); add(0,0,1,1);
    add(1,1,1,1); add(0,1,1,1); add(0,1,1,1); add(0,1,1,1);
    add(0,0,1,1); add(0,0,1,1); add(0,0,1,1);
    add(0,1,1,0); add(0,1,1,0); add(0,1,1,0); add(0,1,1,0);
    add(0,0,1,0); add(0,0,1,0); add(0,0,1,0); add(0,0,0,0);

    reset_n   = 1'b0;
    pulse_in  = 1'b0;
    clear_ovf = 1'b0;
    model_reset();
    #12;
    chk("rst_led",  lit(), 0);
    chk("rst_raw_led", int'(led_out), int'(ACT_LOW));
    chk("rst_busy", int'(busy), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_ovf",  int'(overflow), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].p, vecs[i].c);
      chk($sformatf("vec%0d_led", i),  lit(), vecs[i].led);
      chk($sformatf("vec%0d_busy", i), int'(busy), vecs[i].busy);
      chk($sformatf("vec%0d_pend", i), int'(pending), vecs[i].pend);
      chk($sformatf("vec%0d_ovf", i),  int'(overflow), vecs[i].ovf);
    end

    // Five consecutive pulses: saturate at 3, overflow, then exactly 4 flashes
    rises = 0;
    prev  = lit();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      if (lit() == 1 && prev == 0) rises++;
      prev = lit();
    end
    chk("sat_pend", int'(pending), 3);
    chk("sat_ovf",  int'(overflow), 1);
    step(1'b0, 1'b1);
    chk("clr_ovf", int'(overflow), 0);
    if (lit() == 1 && prev == 0) rises++;
    prev  = lit();
    guard = 0;
    while (busy && guard < 60) begin
      step(1'b0, 1'b0);
      if (lit() == 1 && prev == 0) rises++;
      prev = lit();
      guard++;
    end
    chk("sat_drain_timeout", int'(busy), 0);
    chk("sat_flashes", rises, 4);
    chk("sat_ovf_after", int'(overflow), 0);

    // Asynchronous reset mid-flash with two events queued
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("pre_rst_pend", int'(pending), 2);
    pulse_in = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_led",  lit(), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_pend", int'(pending), 0);
    chk("arst_ovf",  int'(overflow), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0);
    chk_model("post_rst0");
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0);
      chk_model($sformatf("post_rst%0d", i + 1));
    end

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic p, c;
      p = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 6);
      step(p, c);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
